// File: rtl/dm_spi_seq.sv
// dm_spi_seq: APB master sequencer that initialises the SPI core and runs single-frame SPI transactions.
// Optional poll watchdog is built when DM_SPI_SEQ_TIMEOUT_EN is defined.
module dm_spi_seq #(
  parameter logic [15:0] CTRL1_INIT     = 16'h0003,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic        PCLK,
  input  logic        PRESETN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_data,
  input  logic [2:0]  req_ss,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        init_done,
  output logic [6:0]  PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [15:0] PWDATA,
  input  logic [15:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);
  typedef enum logic [3:0] {INIT_CTRL, INIT_MASK, INIT_CLR, IDLE, SEL, TX, POLL, RX, DESEL, RESP} state_t;
  localparam logic [6:0] A_CTRL1 = 7'h00, A_INTCLR = 7'h04, A_RXDATA = 7'h08, A_INTMASK = 7'h10;
  localparam logic [6:0] A_STAT = 7'h20, A_SSEL = 7'h24, A_TXLAST = 7'h28;
  state_t      state, nst;
  logic        sub, nsub, done, accept, poll_ok, tmo, tmo_exit, err_q;
  logic        a_en, a_wr, psel_n, pen_n, pwr_n;
  logic [6:0]  a_addr, paddr_n;
  logic [15:0] a_data, pwdata_n, data_q, rx_q;
  logic [2:0]  ss_q, ss_n;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dm_spi_seq: TIMEOUT_CYCLES must be at least 1");
  end
  assign done      = PSEL & PENABLE & PREADY;
  assign req_ready = (state == IDLE) & init_done;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = state == RESP;
  assign rsp_err   = err_q;
  assign poll_ok   = PRDATA[1] & ~PRDATA[2];
  assign tmo_exit  = (state == POLL) & done & ~poll_ok & tmo;
  // SEL setup is launched on the accept edge, before ss_q is loaded
  assign ss_n      = (state == IDLE) ? req_ss : ss_q;
`ifdef DM_SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) tmo_cnt <= '0;
    else if (state != POLL) tmo_cnt <= '0;
    else if (!tmo) tmo_cnt <= tmo_cnt + TW'(1);
  assign tmo = tmo_cnt == TW'(TIMEOUT_CYCLES);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    nst  = state;
    nsub = sub;
    case (state)
      INIT_CTRL: nst = done ? INIT_MASK : state;
      INIT_MASK: nst = done ? INIT_CLR : state;
      INIT_CLR:  nst = done ? IDLE : state;
      IDLE:      nst = accept ? SEL : state;
      SEL:       nst = done ? TX : state;
      TX:        nst = done ? POLL : state;
      POLL:      nst = !done ? state : poll_ok ? RX : tmo ? DESEL : POLL;
      RX:        nst = done ? DESEL : state;
      DESEL: if (done) begin
        nsub = ~sub;
        nst  = sub ? RESP : DESEL;
      end
      RESP:      nst = IDLE;
      default:   nst = INIT_CTRL;
    endcase
  end
  // access that the state being entered (or re-entered) must issue
  always_comb begin
    a_en   = 1'b1;
    a_wr   = 1'b1;
    a_addr = A_SSEL;
    a_data = 16'h0000;
    case (nst)
      INIT_CTRL: {a_addr, a_data} = {A_CTRL1, CTRL1_INIT};
      INIT_MASK: a_addr = A_INTMASK;
      INIT_CLR:  {a_addr, a_data} = {A_INTCLR, 16'h00FF};
      SEL:       a_data = {8'h00, 8'h01 << ss_n};
      TX:        {a_addr, a_data} = {A_TXLAST, data_q};
      POLL:      {a_wr, a_addr} = {1'b0, A_STAT};
      RX:        {a_wr, a_addr} = {1'b0, A_RXDATA};
      DESEL:     {a_addr, a_data} = nsub ? {A_INTCLR, 16'h00FF} : {A_SSEL, 16'h0000};
      default:   a_en = 1'b0;
    endcase
  end
  always_comb begin
    psel_n   = PSEL;
    pen_n    = PENABLE;
    pwr_n    = PWRITE;
    paddr_n  = PADDR;
    pwdata_n = PWDATA;
    if (PSEL && !PENABLE) pen_n = 1'b1;
    else if (!PSEL || PREADY) begin
      psel_n = a_en;
      pen_n  = 1'b0;
      if (a_en) {pwr_n, paddr_n, pwdata_n} = {a_wr, a_addr, a_data};
    end
  end
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) begin
      state   <= INIT_CTRL;
      sub     <= 1'b0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      state   <= nst;
      sub     <= nsub;
      PSEL    <= psel_n;
      PENABLE <= pen_n;
      PWRITE  <= pwr_n;
      PADDR   <= paddr_n;
      PWDATA  <= pwdata_n;
    end
  always_ff @(posedge PCLK or negedge PRESETN)
    if (!PRESETN) begin
      init_done <= 1'b0;
      err_q     <= 1'b0;
      data_q    <= '0;
      ss_q      <= '0;
      rx_q      <= '0;
      rsp_data  <= '0;
    end else begin
      if (state == INIT_CLR && done) init_done <= 1'b1;
      if (accept) {data_q, ss_q} <= {req_data, req_ss};
      if (accept) err_q <= 1'b0;
      else if (tmo_exit || (done && PSLVERR && state inside {SEL, TX, POLL, RX})) err_q <= 1'b1;
      if (state == RX && done) rx_q <= PRDATA;
      else if (tmo_exit) rx_q <= 16'hFFFF;
      if (state == DESEL && nst == RESP) rsp_data <= rx_q;
    end
endmodule

// File: doc/dm_spi_seq.md
# dm_spi_seq

APB master sequencer that owns the SPI master core's APB slave port and turns single-frame requests from the DM control logic into complete SPI transactions. After reset it configures the SPI core once, then for each request selects the target slave, loads one 16-bit frame, polls for completion, reads back the received frame, and deselects. It sits between the DM command logic and the SPI core on the PCLK domain, and is the only APB master that core sees.

## Interface
Parameters:
- CTRL1_INIT, 16'h0003: value written to CTRL1 during init (bit0 enable, bit1 master).
- TIMEOUT_CYCLES, 4096: poll watchdog limit in PCLK cycles; used only with DM_SPI_SEQ_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock; all logic rising-edge.
- PRESETN  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_data  in  16  TX frame.
- req_ss  in  3  slave index 0..7.
- rsp_valid  out  1  one-cycle pulse, response valid.
- rsp_data  out  16  RX frame; holds until next rsp_valid.
- rsp_err  out  1  qualified by rsp_valid; PSLVERR seen or timeout.
- init_done  out  1  high once init writes complete.
- PADDR  out  7  APB address to SPI core.
- PSEL, PENABLE, PWRITE  out  1 each  APB controls.
- PWDATA  out  16  APB write data.
- PRDATA  in  16  APB read data.
- PREADY, PSLVERR  in  1 each  APB completion and error.

## Operation
- SPI core registers: CTRL1 0x00, INTCLR 0x04, RXDATA 0x08, TXLAST 0x28, INTMASK 0x10, STAT 0x20, SSEL 0x24. STAT bit1 DONE, bit2 RXEMPTY.
- States: INIT_CTRL, INIT_MASK, INIT_CLR, IDLE, SEL, TX, POLL, RX, DESEL, RESP.
- INIT_CTRL writes CTRL1 := CTRL1_INIT; INIT_MASK writes INTMASK := 0; INIT_CLR writes INTCLR := 16'h00FF; then init_done := 1, go to IDLE. Init PSLVERR is ignored.
- IDLE: req_ready = 1 only in IDLE with init_done. On accept, latch req_data and req_ss, go to SEL.
- SEL writes SSEL := 1<<req_ss (8-bit one-hot, upper bits 0). TX writes TXLAST := latched data.
- POLL reads STAT repeatedly; exits to RX when DONE = 1 and RXEMPTY = 0, else re-issues the read immediately.
- RX reads RXDATA into rsp_data. DESEL writes SSEL := 0, then writes INTCLR := 16'h00FF (two accesses, same state via sub-step). RESP pulses rsp_valid one cycle, returns to IDLE.
- Error: any PSLVERR in SEL/TX/POLL/RX sets a sticky err flag; sequence continues to DESEL (never leaves a slave selected). rsp_err = err flag; flag cleared on accept.
- Reset mid-transaction: all state and outputs return to reset values immediately; init reruns.

## Timing
- Each APB access: SETUP cycle (PSEL=1, PENABLE=0), then ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1. PADDR/PWRITE/PWDATA stable from SETUP through completion. Minimum 2 cycles per access; no idle cycle required between back-to-back accesses.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, init_done=0.
- Init with PREADY tied high: 6 cycles; init_done high on 7th cycle after PRESETN deasserts.
- Request latency with PREADY high and DONE on first poll: accept -> rsp_valid = 12 cycles (SEL 2, TX 2, POLL 2, RX 2, DESEL 4); rsp_valid in cycle 13.
- req_data/req_ss sampled only on accept cycle.

## Configuration
- DM_SPI_SEQ_TIMEOUT_EN defined: a counter starts at POLL entry; if TIMEOUT_CYCLES elapse without exit, abandon the poll (after finishing any in-flight APB access), set err flag, rsp_data := 16'hFFFF, go to DESEL.
- Undefined: POLL waits indefinitely; no counter logic synthesized; TIMEOUT_CYCLES unused.

## Test plan
- Reset release, PREADY=1 -> writes 0x00=0003, 0x10=0000, 0x04=00FF in order; init_done high cycle 7.
- Request data 16'hA5C3, ss 5, STAT=16'h0002 first read, RXDATA=16'h1234 -> SSEL=0x20, TXLAST=A5C3, rsp_data=1234, rsp_err=0, rsp_valid 12 cycles after accept.
- PREADY low 3 cycles on TX access -> signals held stable, latency +3, same result.
- PSLVERR on RX read -> SSEL still written 0, rsp_valid with rsp_err=1; next request rsp_err=0.
- With DM_SPI_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, STAT never DONE -> rsp_err=1, rsp_data=FFFF, SSEL=0 written.
- PRESETN asserted during POLL -> PSEL=0 same cycle, init sequence reruns after release.
